clkrst_trace_recorder: RTL and testbench
========================================

CLKRST_TRACE_RECORDER -- requirements
Module: clkrst_trace_recorder

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, record buffer depth in entries (power of two, >=2).
REQ-002 The block SHALL have parameter CNT_W, default 64, cycle-counter and timestamp width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-005 The block SHALL have port trace_en, input, 1, recording enable.
REQ-006 The block SHALL have port mon_rst, input, 1, monitored reset signal, synchronous to clk.
REQ-007 The block SHALL have port rec_valid, output, 1, record available.
REQ-008 The block SHALL have port rec_ready, input, 1, consumer accepts record.
REQ-009 The block SHALL have port rec_type, output, 1, 0=INIT, 1=CHANGE.
REQ-010 The block SHALL have port rec_cycle, output, CNT_W, clkcnt value at the event.
REQ-011 The block SHALL have port rec_value, output, 1, mon_rst value after the event.
REQ-012 The block SHALL have port rec_lost, output, 1, one or more records dropped before this one.
REQ-013 The block SHALL have port clkcnt, output, CNT_W, free-running cycle count.

Function
REQ-014 clkcnt SHALL increment by 1 every clk cycle out of reset, wrapping from all-ones to 0, independent of trace_en.
REQ-015 mon_q SHALL register mon_rst every cycle; a change event is a cycle where mon_rst != mon_q.
REQ-016 FSM states SHALL be IDLE, INIT, RUN; IDLE->INIT when trace_en=1; INIT->RUN unconditionally after one cycle; RUN->IDLE when trace_en=0.
REQ-017 In INIT the block SHALL push {type=INIT, cycle=clkcnt, value=mon_rst}; a change event in the INIT cycle SHALL NOT produce a CHANGE record.
REQ-018 In RUN each change event SHALL push {type=CHANGE, cycle=clkcnt of that cycle, value=mon_rst}.
REQ-019 No records SHALL be pushed in IDLE; re-entering INIT SHALL emit a new INIT record.
REQ-020 A pushed record SHALL appear on the outputs with rec_valid=1 the cycle after the push when the FIFO was empty (latency 1).
REQ-021 Output handshake SHALL be valid/ready: a record transfers when rec_valid&&rec_ready; rec_valid and all rec_* SHALL hold stable until transfer; rec_valid SHALL NOT depend combinationally on rec_ready.
REQ-022 Records SHALL be delivered in push order.
REQ-023 Push when full SHALL succeed if a transfer occurs in the same cycle; otherwise the record is dropped.
REQ-024 A drop SHALL set sticky lost_flag; the next successfully pushed record SHALL carry rec_lost=1 and clear lost_flag in that cycle.
REQ-025 A drop and a successful push cannot coincide (one push per cycle); push and pop simultaneously on an empty FIFO SHALL push only (no pop).
REQ-026 trace_en falling SHALL NOT flush the FIFO; buffered records SHALL remain deliverable.

Reset
REQ-027 On rst assertion, asynchronously: clkcnt=0, mon_q=0, state=IDLE, FIFO empty, lost_flag=0, rec_valid=0, rec_type=0, rec_cycle=0, rec_value=0, rec_lost=0.
REQ-028 Reset mid-operation SHALL discard all buffered records; the first cycle after deassertion SHALL have clkcnt=0 and count from there.

Configuration
REQ-029 With macro CLKRST_REC_DROP_CNT_EN defined, the block SHALL add output drop_cnt, 16 bits, reset 0, incrementing per dropped record, saturating at 16'hFFFF, never cleared except by rst.
REQ-030 Without CLKRST_REC_DROP_CNT_EN, drop_cnt SHALL not exist and no counter logic SHALL be present; all other behaviour identical.

Verification
REQ-031 rst released, trace_en=1 at clkcnt=5, mon_rst=1, rec_ready=1 -> one INIT record cycle=5 value=1 lost=0, rec_valid at clkcnt=6.
REQ-032 In RUN, mon_rst 1->0 seen at clkcnt=20 -> CHANGE record cycle=20 value=0, valid next cycle.
REQ-033 rec_ready=0, FIFO_DEPTH=4, INIT then 5 toggles -> 4 records held, 1 dropped; after ready=1 and another toggle, that fifth delivered record has rec_lost=1; drop_cnt=1 when CLKRST_REC_DROP_CNT_EN defined.
REQ-034 FIFO full, rec_ready=1 and toggle same cycle -> no drop, lost stays 0, order preserved.
REQ-035 Force clkcnt to all-ones via CNT_W=8 run of 255 cycles -> wraps to 0; record at wrap cycle shows cycle=0.
REQ-036 rst asserted with 3 records buffered and rec_valid=1 -> rec_valid=0 immediately (asynchronously); after release, trace_en=1 yields fresh INIT with lost=0.

Source files
------------

// File: rtl/clkrst_trace_recorder.sv
// rtl/clkrst_trace_recorder.sv - clock/reset trace recorder with valid/ready record FIFO (optional drop_cnt via CLKRST_REC_DROP_CNT_EN)
module clkrst_trace_recorder #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trace_en,
    input  logic             mon_rst,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic             rec_type,
    output logic [CNT_W-1:0] rec_cycle,
    output logic             rec_value,
    output logic             rec_lost,
    output logic [CNT_W-1:0] clkcnt
`ifdef CLKRST_REC_DROP_CNT_EN
    ,
    output logic [15:0]      drop_cnt
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int REC_W = CNT_W + 3;
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   clkcnt_q, clkcnt_d;
    logic               mon_q, mon_d;
    logic               lost_q, lost_d;
    logic [REC_W-1:0]   mem_q [FIFO_DEPTH];
    logic [REC_W-1:0]   mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [OCC_W-1:0]   occ_q, occ_d;

    logic               change_evt;
    logic               push_req;
    logic               push_type;
    logic               fifo_full;
    logic               pop;
    logic               push_ok;
    logic               drop;
    logic [REC_W-1:0]   head;

    // Free-running cycle counter and one-cycle history of the monitored reset
    always_comb begin
        clkcnt_d = clkcnt_q + CNT_W'(1);
        mon_d    = mon_rst;
    end

    assign change_evt = (mon_rst != mon_q);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: INIT lasts exactly one cycle, RUN persists while enabled
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (trace_en) state_d = ST_INIT;
            ST_INIT: state_d = ST_RUN;
            ST_RUN:  if (!trace_en) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: INIT always records, RUN records only on a change of mon_rst
    always_comb begin
        push_req  = 1'b0;
        push_type = 1'b0;
        case (state_q)
            ST_INIT: begin
                push_req  = 1'b1;
                push_type = 1'b0;
            end
            ST_RUN: begin
                push_req  = change_evt;
                push_type = 1'b1;
            end
            default: begin
                push_req  = 1'b0;
                push_type = 1'b0;
            end
        endcase
    end

    // FIFO control: a pop frees a slot in the same cycle, so a full FIFO still accepts a push
    always_comb begin
        fifo_full = (occ_q == FULL_OCC);
        pop       = (occ_q != '0) && rec_ready;
        push_ok   = push_req && (!fifo_full || pop);
        drop      = push_req && !push_ok;
    end

    // FIFO storage, pointers, occupancy and the sticky lost flag
    always_comb begin
        mem_d = mem_q;
        if (push_ok) begin
            mem_d[wptr_q] = {lost_q, mon_rst, push_type, clkcnt_q};
        end
        wptr_d = wptr_q + PTR_W'(push_ok);
        rptr_d = rptr_q + PTR_W'(pop);
        occ_d  = occ_q + OCC_W'(push_ok) - OCC_W'(pop);
        lost_d = lost_q;
        if (drop) begin
            lost_d = 1'b1;
        end else if (push_ok) begin
            lost_d = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clkcnt_q <= '0;
            mon_q    <= 1'b0;
            lost_q   <= 1'b0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            occ_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            clkcnt_q <= clkcnt_d;
            mon_q    <= mon_d;
            lost_q   <= lost_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            occ_q    <= occ_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Record outputs come straight from the head entry; zeroed while nothing is pending
    always_comb begin
        head      = mem_q[rptr_q];
        rec_valid = (occ_q != '0);
        rec_cycle = rec_valid ? head[CNT_W-1:0] : '0;
        rec_type  = rec_valid ? head[CNT_W]     : 1'b0;
        rec_value = rec_valid ? head[CNT_W+1]   : 1'b0;
        rec_lost  = rec_valid ? head[CNT_W+2]   : 1'b0;
        clkcnt    = clkcnt_q;
    end

`ifdef CLKRST_REC_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Saturating count of dropped records, cleared only by rst
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Drop counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_clkrst_trace_recorder.sv
// tb/tb_clkrst_trace_recorder.sv - self-checking bench for clkrst_trace_recorder
module tb_clkrst_trace_recorder;

    localparam int DEPTH = 4;
    localparam int CW    = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          trace_en = 1'b0;
    logic          mon_rst = 1'b0;
    logic          rec_ready = 1'b0;
    logic          rec_valid, rec_type, rec_value, rec_lost;
    logic [CW-1:0] rec_cycle, clkcnt;
`ifdef CLKRST_REC_DROP_CNT_EN
    logic [15:0]   drop_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    clkrst_trace_recorder #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .trace_en  (trace_en),
        .mon_rst   (mon_rst),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .rec_type  (rec_type),
        .rec_cycle (rec_cycle),
        .rec_value (rec_value),
        .rec_lost  (rec_lost),
        .clkcnt    (clkcnt)
`ifdef CLKRST_REC_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    typedef struct {
        bit typ;
        int cyc;
        bit val;
        bit lost;
    } rec_t;

    rec_t q[$];
    rec_t got[$];
    int   m_cnt;
    bit   m_prev, m_init_now, m_active, m_lost;
    int   m_drops;

    function automatic void model_reset();
        q.delete();
        m_cnt = 0; m_prev = 0; m_init_now = 0; m_active = 0; m_lost = 0; m_drops = 0;
    endfunction

    // One clock of the recorder's rules, using the inputs that will be sampled at the next edge
    function automatic void model_step();
        bit   do_pop, do_push;
        rec_t r;
        do_pop  = (q.size() > 0) && rec_ready;
        do_push = 0;
        r.typ = 0; r.cyc = m_cnt; r.val = mon_rst; r.lost = 0;
        if (m_init_now) begin
            do_push = 1; m_init_now = 0; m_active = 1;
        end else if (m_active) begin
            if (mon_rst != m_prev) begin do_push = 1; r.typ = 1; end
            if (!trace_en) m_active = 0;
        end else if (trace_en) begin
            m_init_now = 1;
        end
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
            if (q.size() < DEPTH) begin
                r.lost = m_lost; m_lost = 0; q.push_back(r);
            end else begin
                m_lost = 1; m_drops++;
            end
        end
        m_prev = mon_rst;
        m_cnt  = (m_cnt + 1) % 256;
    endfunction

    task automatic tick();
        rec_t r;
        @(negedge clk);
        if (rec_valid && rec_ready) begin
            r.typ = rec_type; r.cyc = int'(rec_cycle); r.val = rec_value; r.lost = rec_lost;
            got.push_back(r);
        end
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; trace_en = 1'b0; mon_rst = 1'b0; rec_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        got.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if ({rec_valid, rec_type, rec_value, rec_lost} !== 4'b0) begin
            n_bad++; $display("FAIL reset_flags: got %b exp 0000", {rec_valid, rec_type, rec_value, rec_lost});
        end
        n_cmp++; if (rec_cycle !== '0) begin n_bad++; $display("FAIL reset_rec_cycle: got %0d exp 0", rec_cycle); end
        n_cmp++; if (clkcnt !== '0) begin n_bad++; $display("FAIL reset_clkcnt: got %0d exp 0", clkcnt); end
`ifdef CLKRST_REC_DROP_CNT_EN
        n_cmp++; if (drop_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_drop_cnt: got %0d exp 0", drop_cnt); end
`endif
        tick();
        n_cmp++; if (clkcnt !== 8'd1) begin n_bad++; $display("FAIL clkcnt_first_inc: got %0d exp 1", clkcnt); end
    endtask

    task automatic test_init_latency();
        do_reset();
        mon_rst = 1'b1; rec_ready = 1'b1;
        repeat (4) tick();
        n_cmp++; if (clkcnt !== 8'd4) begin n_bad++; $display("FAIL init_pre_clkcnt: got %0d exp 4", clkcnt); end
        trace_en = 1'b1;
        tick();
        n_cmp++; if (rec_valid !== 1'b0) begin n_bad++; $display("FAIL init_no_early_valid: got %b exp 0", rec_valid); end
        tick();
        n_cmp++; if (clkcnt !== 8'd6 || rec_valid !== 1'b1) begin
            n_bad++; $display("FAIL init_latency: got clkcnt=%0d valid=%b exp clkcnt=6 valid=1", clkcnt, rec_valid);
        end
        n_cmp++; if ({rec_type, rec_value, rec_lost, rec_cycle} !== {3'b010, 8'd5}) begin
            n_bad++; $display("FAIL init_record: got type=%b val=%b lost=%b cyc=%0d exp type=0 val=1 lost=0 cyc=5",
                              rec_type, rec_value, rec_lost, rec_cycle);
        end
    endtask

    task automatic test_change();
        repeat (20 - m_cnt) tick();
        mon_rst = 1'b0;
        tick();
        n_cmp++; if ({rec_valid, rec_type, rec_value, rec_lost, rec_cycle} !== {4'b1100, 8'd20}) begin
            n_bad++; $display("FAIL change_record: got valid=%b type=%b val=%b lost=%b cyc=%0d exp 1 1 0 0 cyc=20",
                              rec_valid, rec_type, rec_value, rec_lost, rec_cycle);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        trace_en = 1'b1;
        tick();
        mon_rst = ~mon_rst;
        tick();
        repeat (4) begin mon_rst = ~mon_rst; tick(); end
        n_cmp++; if (rec_valid !== 1'b1 || rec_type !== 1'b0 || rec_lost !== 1'b0) begin
            n_bad++; $display("FAIL ovf_head: got valid=%b type=%b lost=%b exp 1 0 0", rec_valid, rec_type, rec_lost);
        end
`ifdef CLKRST_REC_DROP_CNT_EN
        n_cmp++; if (drop_cnt !== 16'd1) begin n_bad++; $display("FAIL ovf_drop_cnt: got %0d exp 1", drop_cnt); end
`endif
        rec_ready = 1'b1; mon_rst = ~mon_rst;
        tick();
        repeat (6) tick();
        n_cmp++; if (got.size() != 5) begin
            n_bad++; $display("FAIL ovf_count: got %0d exp 5", got.size());
        end else begin
            n_cmp++; if ({got[0].lost, got[1].lost, got[2].lost, got[3].lost, got[4].lost} !== 5'b00001) begin
                n_bad++; $display("FAIL ovf_lost_pattern: got %b%b%b%b%b exp 00001",
                                  got[0].lost, got[1].lost, got[2].lost, got[3].lost, got[4].lost);
            end
            n_cmp++; if ({got[0].typ, got[1].typ, got[2].typ, got[3].typ, got[4].typ} !== 5'b01111) begin
                n_bad++; $display("FAIL ovf_types: got %b%b%b%b%b exp 01111",
                                  got[0].typ, got[1].typ, got[2].typ, got[3].typ, got[4].typ);
            end
        end
    endtask

    task automatic test_full_pop();
        got.delete();
        rec_ready = 1'b0;
        repeat (4) begin mon_rst = ~mon_rst; tick(); end
        rec_ready = 1'b1; mon_rst = ~mon_rst;
        tick();
        repeat (6) tick();
        n_cmp++; if (got.size() != 5) begin
            n_bad++; $display("FAIL fullpop_count: got %0d exp 5", got.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++; if (got[i].lost !== 1'b0 || (i > 0 && got[i].cyc != got[i-1].cyc + 1)) begin
                    n_bad++; $display("FAIL fullpop_rec%0d: got lost=%b cyc=%0d exp lost=0 consecutive cycles",
                                      i, got[i].lost, got[i].cyc);
                end
            end
        end
`ifdef CLKRST_REC_DROP_CNT_EN
        n_cmp++; if (drop_cnt !== 16'd1) begin n_bad++; $display("FAIL fullpop_drop_cnt: got %0d exp 1", drop_cnt); end
`endif
    endtask

    task automatic test_wrap();
        rec_ready = 1'b1;
        repeat ((255 - m_cnt + 256) % 256) tick();
        n_cmp++; if (clkcnt !== 8'hFF) begin n_bad++; $display("FAIL wrap_pre: got %0d exp 255", clkcnt); end
        tick();
        n_cmp++; if (clkcnt !== 8'h00) begin n_bad++; $display("FAIL wrap_zero: got %0d exp 0", clkcnt); end
        mon_rst = ~mon_rst;
        tick();
        n_cmp++; if ({rec_valid, rec_type, rec_cycle} !== {2'b11, 8'd0}) begin
            n_bad++; $display("FAIL wrap_record: got valid=%b type=%b cyc=%0d exp 1 1 cyc=0", rec_valid, rec_type, rec_cycle);
        end
    endtask

    task automatic test_async_reset();
        rec_ready = 1'b1;
        repeat (2) tick();
        rec_ready = 1'b0;
        repeat (5) begin mon_rst = ~mon_rst; tick(); end
        rec_ready = 1'b1;
        tick();
        rec_ready = 1'b0;
        n_cmp++; if (rec_valid !== 1'b1 || q.size() != 3) begin
            n_bad++; $display("FAIL areset_pre: got valid=%b model_depth=%0d exp 1 3", rec_valid, q.size());
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if ({rec_valid, rec_type, rec_value, rec_lost, rec_cycle, clkcnt} !== '0) begin
            n_bad++; $display("FAIL areset_immediate: got valid=%b cyc=%0d clkcnt=%0d exp all 0", rec_valid, rec_cycle, clkcnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b0; model_reset(); got.delete();
        trace_en = 1'b1; rec_ready = 1'b1;
        tick();
        tick();
        n_cmp++; if ({rec_valid, rec_type, rec_lost, rec_cycle, clkcnt} !== {3'b100, 8'd1, 8'd2}) begin
            n_bad++; $display("FAIL areset_fresh_init: got valid=%b type=%b lost=%b cyc=%0d clkcnt=%0d exp 1 0 0 cyc=1 clkcnt=2",
                              rec_valid, rec_type, rec_lost, rec_cycle, clkcnt);
        end
    endtask

    task automatic test_random();
        logic [2*CW+3:0] obs, exp;
        bit ev;
        do_reset();
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 19) == 0) trace_en = ~trace_en;
            if ($urandom_range(0, 9) < 3) mon_rst = ~mon_rst;
            rec_ready = ($urandom_range(0, 9) < ((i / 150) % 2 == 0 ? 7 : 2));
            tick();
            ev = (q.size() != 0);
            if (ev) begin
                obs = {rec_valid, clkcnt, rec_type, rec_value, rec_lost, rec_cycle};
                exp = {1'b1, CW'(m_cnt), q[0].typ, q[0].val, q[0].lost, CW'(q[0].cyc)};
            end else begin
                obs = {rec_valid, clkcnt, {(CW+3){1'b0}}};
                exp = {1'b0, CW'(m_cnt), {(CW+3){1'b0}}};
            end
            n_cmp++; if (obs !== exp) begin
                n_bad++; $display("FAIL random_cycle%0d: got %h exp %h ({valid,clkcnt,type,value,lost,cycle})", i, obs, exp);
            end
        end
`ifdef CLKRST_REC_DROP_CNT_EN
        n_cmp++; if (drop_cnt !== 16'((m_drops > 65535) ? 65535 : m_drops)) begin
            n_bad++; $display("FAIL random_drop_cnt: got %0d exp %0d", drop_cnt, m_drops);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_init_latency();
        test_change();
        test_overflow();
        test_full_pop();
        test_wrap();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
